// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader for the fft block.
// Bit-reversed writes into two ping-pong banks.
module fft_frame_loader #(
  parameter int N     = 16,
  parameter int W     = 16,
  parameter int LOG2N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_im,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_real [0:N-1],
  output logic [W-1:0] out_im   [0:N-1],
  output logic         frame_err
);

  logic [W-1:0]     re_q [2][N];
  logic [W-1:0]     im_q [2][N];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [LOG2N-1:0] cnt;
  logic             err_q;
  logic             acc_in;
  logic             acc_out;
  logic             at_end;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] k
  );
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++)
      r[b] = k[LOG2N-1-b];
    return r;
  endfunction

  assign in_ready  = !full[wr_sel];
  assign acc_in    = in_valid & in_ready;
  assign out_valid = full[rd_sel];
  assign acc_out   = out_valid & out_ready;
  assign at_end    = (cnt == LOG2N'(N-1));
  assign frame_err = err_q;

  // present the read bank straight from its registers
  always_comb begin
    for (int i = 0; i < N; i++) begin
      out_real[i] = re_q[rd_sel][i];
      out_im[i]   = im_q[rd_sel][i];
    end
  end

  // bank fill, frame bookkeeping and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          re_q[b][i] <= '0;
          im_q[b][i] <= '0;
        end
      end
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (acc_out) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
      end
      if (acc_in) begin
        re_q[wr_sel][bitrev(cnt)] <= in_real;
        im_q[wr_sel][bitrev(cnt)] <= in_im;
        if (at_end) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          cnt          <= '0;
          err_q        <= !in_last;
        end else if (in_last) begin
          cnt   <= '0;
          err_q <= 1'b1;
        end else begin
          cnt <= cnt + LOG2N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader.
// Hand-computed bit-reversed frame checks.
module tb_fft_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_real = '0;
  logic [15:0] in_im = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_real [0:15];
  logic [15:0] out_im   [0:15];
  logic        frame_err;

  int npass = 0;
  int ntot  = 0;
  int err_cnt = 0;
  int err0;

  fft_frame_loader #(.N(16), .W(16), .LOG2N(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_real(in_real),
    .in_im(in_im),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real(out_real),
    .out_im(out_im),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // cycles with frame_err high
  always @(posedge clk)
    if (frame_err === 1'b1) err_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  task automatic pulse();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // offer one sample until accepted (bounded)
  task automatic send(input logic [15:0] re,
                      input logic [15:0] im,
                      input logic last);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_real  = re;
    in_im    = im;
    in_last  = last;
    forever begin
      acc = in_ready;
      step();
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic frame(input logic [15:0] base,
                       input logic last_ok);
    for (int k = 0; k < 16; k++)
      send(base + 16'(k), 16'(k), last_ok && k == 15);
  endtask

  initial begin
    step();
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_err", frame_err, 0);
    chk("rst_re0", out_real[0], 0);
    rst = 1'b0;
    step();

    // basic frame
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++)
      send(16'(k * 256), 16'(-k), k == 15);
    chk("b_ov", out_valid, 1);
    chk("b_re8", out_real[8], 16'd256);
    chk("b_re12", out_real[12], 16'd768);
    chk("b_im12", out_im[12], 16'hfffd);
    chk("b_re0", out_real[0], 0);
    idle();
    chk("b_drain", out_valid, 0);
    chk("b_err", err_cnt, 0);
    out_ready = 1'b0;

    // backpressure
    frame(16'h1000, 1);
    frame(16'h2000, 1);
    chk("bp_ir0", in_ready, 0);
    in_valid = 1'b1;
    in_real  = 16'h3000;
    in_im    = 16'h0;
    in_last  = 1'b0;
    step();
    step();
    chk("bp_hold", in_ready, 0);
    chk("bp_re0", out_real[0], 16'h1000);
    chk("bp_re8", out_real[8], 16'h1001);
    pulse();
    chk("bp_ov", out_valid, 1);
    chk("bp_f2", out_real[0], 16'h2000);
    chk("bp_ir1", in_ready, 1);
    for (int k = 0; k < 16; k++)
      send(16'h3000 + 16'(k), 16'(k), k == 15);
    in_valid = 1'b0;
    chk("bp_full", in_ready, 0);
    chk("bp_f2b", out_real[4], 16'h2002);
    pulse();
    chk("bp_f3", out_real[0], 16'h3000);
    chk("bp_f3b", out_real[8], 16'h3001);
    chk("bp_f3c", out_real[15], 16'h300f);
    pulse();
    chk("bp_empty", out_valid, 0);

    // simultaneous output accept and completion
    frame(16'h4000, 1);
    for (int k = 0; k < 15; k++)
      send(16'h5000 + 16'(k), 16'(k), 0);
    out_ready = 1'b1;
    send(16'h500f, 16'd15, 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("sim_ov", out_valid, 1);
    chk("sim_re0", out_real[0], 16'h5000);
    chk("sim_re8", out_real[8], 16'h5001);
    chk("sim_re15", out_real[15], 16'h500f);
    chk("sim_ir", in_ready, 1);
    pulse();
    chk("sim_empty", out_valid, 0);

    // early in_last
    err0 = err_cnt;
    for (int k = 0; k < 6; k++)
      send(16'h7700 + 16'(k), 16'(k), k == 5);
    for (int k = 0; k < 16; k++)
      send(16'd100 + 16'(k), 16'(k), k == 15);
    idle();
    chk("el_err", err_cnt - err0, 1);
    chk("el_ov", out_valid, 1);
    chk("el_re0", out_real[0], 16'd100);
    chk("el_re8", out_real[8], 16'd101);
    chk("el_re4", out_real[4], 16'd102);
    chk("el_re10", out_real[10], 16'd105);
    chk("el_re5", out_real[5], 16'd110);
    pulse();
    chk("el_one", out_valid, 0);

    // missing in_last
    err0 = err_cnt;
    frame(16'h6000, 0);
    chk("ml_now", frame_err, 1);
    chk("ml_ov", out_valid, 1);
    chk("ml_re12", out_real[12], 16'h6003);
    idle();
    chk("ml_err", err_cnt - err0, 1);
    chk("ml_off", frame_err, 0);
    pulse();

    // async reset mid-frame with a frame pending
    frame(16'h8000, 1);
    for (int k = 0; k < 9; k++)
      send(16'h8800 + 16'(k), 16'(k), 0);
    in_valid = 1'b0;
    err0 = err_cnt;
    chk("ar_pend", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_re0", out_real[0], 0);
    chk("ar_re8", out_real[8], 0);
    chk("ar_im8", out_im[8], 0);
    chk("ar_ir", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    frame(16'h9000, 1);
    in_valid = 1'b0;
    chk("ar_ov2", out_valid, 1);
    chk("ar_n0", out_real[0], 16'h9000);
    chk("ar_n8", out_real[8], 16'h9001);
    chk("ar_n5", out_real[5], 16'h900a);
    idle();
    chk("ar_noerr", err_cnt - err0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
